// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the 65C02 bus bridge: state encoding and defaults.
package cpu_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } bridge_state_t;

  localparam logic [15:0] FAST_TOP_DEFAULT = 16'h01FF;
  localparam logic [7:0]  ERR_DATA_DEFAULT = 8'hFF;
  localparam int          TIMEOUT_DEFAULT  = 16;

  // True when the address falls in the zero-wait internal RAM window (base 0).
  function automatic logic is_fast(input logic [15:0] addr, input logic [15:0] top);
    return (addr <= top);
  endfunction

endpackage

// File: rtl/zp_ram.sv
// 512x8 synchronous single-port RAM for zero page and stack.
// Registered read port; the output register clears on reset so DI starts at 0.
module zp_ram (
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic       re,
  input  logic [8:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata
);

  logic [7:0] mem [512];

  // Array write on the accepting edge of a fast write.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  // Read register only moves on a fast read so it holds its value otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= 8'h00;
    else if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/cpu_mem_bridge.sv
// 65C02 bus responder: internal RAM for the low window, slow req/ack port
// for everything else, holding the CPU with RDY=0 until the slow access ends.
module cpu_mem_bridge
  import cpu_bus_pkg::*;
#(
  parameter logic [15:0] FAST_TOP = FAST_TOP_DEFAULT,
  parameter int          TIMEOUT  = TIMEOUT_DEFAULT,
  parameter logic [7:0]  ERR_DATA = ERR_DATA_DEFAULT
) (
  input  logic        clk,
  input  logic        RST,
  input  logic [15:0] AB,
  input  logic [7:0]  DO,
  input  logic        WE,
  output logic [7:0]  DI,
  output logic        RDY,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic        err,
  input  logic        err_clr
);

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  bridge_state_t state, next_state;
  logic [15:0]   cnt;
  logic [7:0]    captured;
  logic [7:0]    di_slow;
  logic          di_from_ram;
  logic [7:0]    ram_rdata;
  logic          fast_hit;
  logic          start_req;
  logic          ack_fin;
  logic          timeout_fin;

  assign fast_hit = is_fast(AB, FAST_TOP);
  assign RDY      = RST | fast_hit | (state == DONE);
  assign DI       = di_from_ram ? ram_rdata : di_slow;

  zp_ram u_zp_ram (
    .clk   (clk),
    .rst   (RST),
    .we    (fast_hit & WE & ~RST),
    .re    (fast_hit & ~WE & ~RST),
    .addr  (AB[8:0]),
    .wdata (DO),
    .rdata (ram_rdata)
  );

  // State register; reset abandons any outstanding slow request.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state decode plus one-cycle event strobes for the datapath.
  always_comb begin
    next_state  = state;
    start_req   = 1'b0;
    ack_fin     = 1'b0;
    timeout_fin = 1'b0;
    case (state)
      IDLE: begin
        if (!fast_hit) begin
          start_req  = 1'b1;
          next_state = REQ;
        end
      end
      REQ: begin
        if (mem_ack) begin
          ack_fin    = 1'b1;
          next_state = DONE;
        end else if (cnt == CNT_LAST) begin
          timeout_fin = 1'b1;
          next_state  = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Slow-port request registers, timeout counter and captured read data.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 16'h0000;
      mem_wdata <= 8'h00;
      cnt       <= 16'h0000;
      captured  <= 8'h00;
    end else begin
      if (start_req) begin
        mem_req   <= 1'b1;
        mem_we    <= WE;
        mem_addr  <= AB;
        mem_wdata <= DO;
        cnt       <= 16'h0000;
      end
      if (state == REQ && !mem_ack) cnt <= cnt + 16'h0001;
      if (ack_fin) begin
        mem_req <= 1'b0;
        if (!mem_we) captured <= mem_rdata;
      end
      if (timeout_fin) begin
        mem_req  <= 1'b0;
        captured <= ERR_DATA;
      end
    end
  end

  // Sticky error flag; a timeout in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or posedge RST) begin
    if (RST)              err <= 1'b0;
    else if (timeout_fin) err <= 1'b1;
    else if (err_clr)     err <= 1'b0;
  end

  // DI source select: RAM register after a fast read, captured data after a slow read.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      di_slow     <= 8'h00;
      di_from_ram <= 1'b0;
    end else if (state == DONE) begin
      if (!mem_we) begin
        di_slow     <= captured;
        di_from_ram <= 1'b0;
      end
    end else if (fast_hit && !WE) begin
      di_from_ram <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cpu_mem_bridge.sv
// Directed self-checking bench for cpu_mem_bridge.
module tb_cpu_mem_bridge;
  import cpu_bus_pkg::*;

  logic        clk;
  logic        RST;
  logic [15:0] AB;
  logic [7:0]  DO;
  logic        WE;
  logic [7:0]  DI;
  logic        RDY;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        err;
  logic        err_clr;

  int tests_run = 0;
  int tests_failed = 0;

  int          low_cycles;
  int          req_cycles;
  logic [15:0] seen_addr;
  logic        seen_we;
  logic [7:0]  seen_wdata;

  cpu_mem_bridge dut (
    .clk       (clk),
    .RST       (RST),
    .AB        (AB),
    .DO        (DO),
    .WE        (WE),
    .DI        (DI),
    .RDY       (RDY),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .err       (err),
    .err_clr   (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Runs one slow access; ack_at is the 1-based REQ cycle carrying mem_ack (0 = never).
  task automatic slow_access(input logic [15:0] addr, input logic wr, input logic [7:0] wdata,
                             input int ack_at, input logic [7:0] rdata,
                             output int low, output int reqc,
                             output logic [15:0] s_addr, output logic s_we,
                             output logic [7:0] s_wdata);
    AB = addr; WE = wr; DO = wdata;
    low = 0; reqc = 0; s_addr = 16'h0; s_we = 1'b0; s_wdata = 8'h0;
    #1;
    for (int i = 0; i < 40 && !RDY; i++) begin
      low++;
      if (mem_req) begin
        reqc++;
        if (reqc == 1) begin
          s_addr = mem_addr; s_we = mem_we; s_wdata = mem_wdata;
        end
        if (reqc == ack_at) begin
          mem_ack = 1'b1; mem_rdata = rdata;
        end
      end
      tick();
      mem_ack = 1'b0; mem_rdata = 8'h00;
    end
    check("rdy_in_done", 16'(RDY), 16'h1);
    check("req_dropped_in_done", 16'(mem_req), 16'h0);
    tick();
    AB = 16'h0000; WE = 1'b1; DO = 8'h00;
  endtask

  initial begin
    RST = 1'b0; AB = 16'h8000; DO = 8'h00; WE = 1'b0;
    mem_ack = 1'b0; mem_rdata = 8'h00; err_clr = 1'b0;
    #2 RST = 1'b1;
    tick(); tick();

    // Reset state with a slow address on the bus
    check("rst_rdy", 16'(RDY), 16'h1);
    check("rst_di", 16'(DI), 16'h00);
    check("rst_mem_req", 16'(mem_req), 16'h0);
    check("rst_err", 16'(err), 16'h0);
    RST = 1'b0;
    #1;
    check("release_rdy", 16'(RDY), 16'h0);

    // Fast path writes and reads, including the top of the window
    AB = 16'h0123; WE = 1'b1; DO = 8'h5A;
    #1;
    check("fast_wr_rdy", 16'(RDY), 16'h1);
    tick();
    AB = 16'h01FF; WE = 1'b1; DO = 8'hA5;
    #1;
    check("fast_wr_top_rdy", 16'(RDY), 16'h1);
    tick();
    AB = 16'h0123; WE = 1'b0;
    #1;
    check("fast_rd_rdy", 16'(RDY), 16'h1);
    tick();
    check("fast_rd_di", 16'(DI), 16'h5A);
    check("fast_mem_req", 16'(mem_req), 16'h0);
    AB = 16'h01FF; WE = 1'b0;
    tick();
    check("fast_rd_top_di", 16'(DI), 16'hA5);
    check("fast_rdy_after", 16'(RDY), 16'h1);
    check("fast_mem_req2", 16'(mem_req), 16'h0);
    AB = 16'h0200; WE = 1'b0;
    #1;
    check("boundary_0200_rdy", 16'(RDY), 16'h0);

    // Slow read, ack in the fourth REQ cycle
    slow_access(16'h8000, 1'b0, 8'h00, 4, 8'hC3, low_cycles, req_cycles, seen_addr, seen_we, seen_wdata);
    check("slow_rd_low", 16'(low_cycles), 16'd5);
    check("slow_rd_reqc", 16'(req_cycles), 16'd4);
    check("slow_rd_addr", seen_addr, 16'h8000);
    check("slow_rd_we", 16'(seen_we), 16'h0);
    check("slow_rd_di", 16'(DI), 16'hC3);
    check("slow_rd_err", 16'(err), 16'h0);

    // Slow write, ack in the first REQ cycle
    slow_access(16'hD000, 1'b1, 8'h77, 1, 8'h00, low_cycles, req_cycles, seen_addr, seen_we, seen_wdata);
    check("slow_wr_low", 16'(low_cycles), 16'd2);
    check("slow_wr_addr", seen_addr, 16'hD000);
    check("slow_wr_we", 16'(seen_we), 16'h1);
    check("slow_wr_wdata", 16'(seen_wdata), 16'h77);
    check("slow_wr_di_held", 16'(DI), 16'hC3);
    AB = 16'h0123; WE = 1'b0;
    tick();
    check("ram_kept_0123", 16'(DI), 16'h5A);
    AB = 16'h01FF; WE = 1'b0;
    tick();
    check("ram_kept_01ff", 16'(DI), 16'hA5);

    // Timeout with no ack
    slow_access(16'h9000, 1'b0, 8'h00, 0, 8'h00, low_cycles, req_cycles, seen_addr, seen_we, seen_wdata);
    check("to_reqc", 16'(req_cycles), 16'd16);
    check("to_low", 16'(low_cycles), 16'd17);
    check("to_di", 16'(DI), 16'hFF);
    check("to_err", 16'(err), 16'h1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("err_cleared", 16'(err), 16'h0);

    // Ack on the final count wins over timeout
    slow_access(16'hA000, 1'b0, 8'h00, 16, 8'h3C, low_cycles, req_cycles, seen_addr, seen_we, seen_wdata);
    check("lastack_reqc", 16'(req_cycles), 16'd16);
    check("lastack_di", 16'(DI), 16'h3C);
    check("lastack_err", 16'(err), 16'h0);

    // Reset two cycles into REQ, then a fresh request
    AB = 16'hB000; WE = 1'b0;
    tick();
    check("rstreq_req_on", 16'(mem_req), 16'h1);
    tick();
    RST = 1'b1;
    #1;
    check("rstreq_req_dropped", 16'(mem_req), 16'h0);
    check("rstreq_state", 16'(dut.state), 16'(IDLE));
    check("rstreq_rdy", 16'(RDY), 16'h1);
    check("rstreq_di", 16'(DI), 16'h00);
    tick();
    RST = 1'b0;
    #1;
    check("rstreq_release_rdy", 16'(RDY), 16'h0);
    tick();
    check("reissue_req", 16'(mem_req), 16'h1);
    check("reissue_addr", mem_addr, 16'hB000);
    check("reissue_state", 16'(dut.state), 16'(REQ));
    mem_ack = 1'b1; mem_rdata = 8'h11;
    tick();
    mem_ack = 1'b0; mem_rdata = 8'h00;
    check("reissue_done_rdy", 16'(RDY), 16'h1);
    tick();
    AB = 16'h0000; WE = 1'b1; DO = 8'h00;
    check("reissue_di", 16'(DI), 16'h11);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
